// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand fetch (decode) stage: widths, instruction
// field positions, opcodes, FSM states, the pipeline payload and decode helpers.
package operand_fetch_stage_pkg;

  localparam int unsigned DW    = 8;   // datapath width, fixed by the byte mux
  localparam int unsigned NREGS = 8;   // architectural registers
  localparam int unsigned AW    = 3;   // register address width
  localparam int unsigned IW    = 16;  // instruction width
  localparam int unsigned OPW   = 4;   // opcode width

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [OPW-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h8,
    OP_LDI  = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Registered operand bundle handed to the execute stage
  typedef struct packed {
    logic [OPW-1:0] op;
    logic [AW-1:0]  rd;
    logic           we;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b_reg;
    logic [DW-1:0]  op_b_imm;
    logic           imm_sel;
    logic           illegal;
  } opf_payload_t;

  function automatic logic is_rtype(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

  function automatic logic is_imm(input logic [OPW-1:0] op);
    return (op == OP_ADDI) || (op == OP_LDI);
  endfunction

  function automatic logic is_legal(input logic [OPW-1:0] op);
    return is_rtype(op) || is_imm(op) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/regfile_8x8.sv
// 8 x 8-bit register file: two combinational read ports, one synchronous
// write port. R0 always reads zero and ignores writes.
// Optional macro DECODE_WB_BYPASS_EN: a read of the address being written this
// cycle returns the write data instead of the stored value.
// Ports: clk, rst (sync, active-high), we/waddr/wdata (write),
//        raddr_a/rdata_a, raddr_b/rdata_b (reads).
module regfile_8x8
  import operand_fetch_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic          wr_en;

  assign wr_en = we && (waddr != AW'(0));

  // Next register contents
  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NREGS); i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports; R0 is forced to zero regardless of storage
  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
`ifdef DECODE_WB_BYPASS_EN
    if (wr_en && (waddr == raddr_a)) rdata_a = wdata;
    if (wr_en && (waddr == raddr_b)) rdata_b = wdata;
`endif
    if (raddr_a == AW'(0)) rdata_a = '0;
    if (raddr_b == AW'(0)) rdata_b = '0;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode stage: decodes a 16-bit instruction, reads rs1/rs2 from the register
// file and registers operands for the execute stage (a = op_b_reg,
// b = op_b_imm, s = imm_sel of the downstream byte mux). Hosts the writeback
// port. HALT parks the stage until a resume pulse.
// Optional macro DECODE_WB_BYPASS_EN: same-cycle writeback-to-read forwarding.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/instr (fetch side);
//        resume; wb_we/wb_addr/wb_data (writeback); out_valid/out_ready,
//        out_op, out_rd, out_we, op_a, op_b_reg, op_b_imm, imm_sel, illegal
//        (execute side); halted.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  instr,
  input  logic           resume,
  input  logic           wb_we,
  input  logic [AW-1:0]  wb_addr,
  input  logic [DW-1:0]  wb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_op,
  output logic [AW-1:0]  out_rd,
  output logic           out_we,
  output logic [DW-1:0]  op_a,
  output logic [DW-1:0]  op_b_reg,
  output logic [DW-1:0]  op_b_imm,
  output logic           imm_sel,
  output logic           illegal,
  output logic           halted
);

  state_e        state_q, state_d;
  logic          out_valid_q, out_valid_d;
  opf_payload_t  pl_q, pl_d;
  opf_payload_t  dec;

  logic [OPW-1:0] op;
  logic [AW-1:0]  rd_f, rs1_f, rs2_f;
  logic [AW-1:0]  raddr_a;
  logic [DW-1:0]  rdata_a, rdata_b;
  logic           accept;

  assign op    = instr[OP_LSB  +: OPW];
  assign rd_f  = instr[RD_LSB  +: AW];
  assign rs1_f = instr[RS1_LSB +: AW];
  assign rs2_f = instr[RS2_LSB +: AW];

  // ADDI reads its source from the rd field
  assign raddr_a = (op == OP_ADDI) ? rd_f : rs1_f;

  regfile_8x8 u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (rs2_f),
    .rdata_b (rdata_b)
  );

  // Instruction decode into the payload that will be registered on accept
  always_comb begin
    dec          = '0;
    dec.op       = op;
    dec.rd       = rd_f;
    dec.op_b_reg = rdata_b;
    dec.op_b_imm = instr[IMM_LSB +: DW];
    dec.op_a     = (op == OP_LDI) ? DW'(0) : rdata_a;
    dec.we       = is_rtype(op) || is_imm(op);
    dec.imm_sel  = is_imm(op);
    dec.illegal  = !is_legal(op);
  end

  // Handshake, pipeline register next-state and FSM
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    pl_d        = pl_q;
    in_ready    = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;

    if (accept) begin
      pl_d        = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_RUN:    if (accept && (op == OP_HALT)) state_d = ST_HALTED;
      ST_HALTED: if (resume) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      pl_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      pl_q        <= pl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = pl_q.op;
  assign out_rd    = pl_q.rd;
  assign out_we    = pl_q.we;
  assign op_a      = pl_q.op_a;
  assign op_b_reg  = pl_q.op_b_reg;
  assign op_b_imm  = pl_q.op_b_imm;
  assign imm_sel   = pl_q.imm_sel;
  assign illegal   = pl_q.illegal;
  assign halted    = (state_q == ST_HALTED);

endmodule
